imm_decode_stage: RTL and testbench
===================================

// Module: imm_decode_stage
// PURPOSE
//  Registered immediate-decode pipeline stage between fetch and the scoreboard issue logic.
//  Accepts one instruction per cycle on a valid/ready handshake.
//  Decodes the RISC-V immediate format, then sign- or zero-extends the immediate to XLEN.
//  Flags unsupported encodings and presents the result one cycle later through a 2-entry skid buffer.
//  Generalises the combinational immediate extender with:
//   - parametrised XLEN;
//   - RV64 shift and OP-IMM-32 handling;
//   - CSR zimm;
//   - a defined illegal-opcode response;
//   - back-pressure and flush.
// PARAMETERS
//  XLEN     32  extended immediate width; legal values 32 or 64
//  TAG_W    5   width of sideband tag (ROB/scoreboard id) carried with each instruction
//  EN_CSR   1   1: decode SYSTEM (1110011) zimm format; 0: SYSTEM reports illegal
// PORTS
//  clk          in   1      clock
//  rst          in   1      synchronous reset, active-high
//  flush        in   1      synchronous pipeline flush, discards all held entries
//  in_valid     in   1      upstream instruction valid
//  in_ready     out  1      stage can accept an instruction this cycle
//  in_instr     in   32     raw instruction word
//  in_tag       in   TAG_W  sideband tag
//  out_valid    out  1      decoded entry valid
//  out_ready    in   1      downstream accepts entry
//  out_instr    out  32     instruction word, passed through
//  out_imm      out  XLEN   extended immediate
//  out_fmt      out  3      format code: NONE=0, I=1, S=2, B=3, U=4, J=5, SH=6, Z=7
//  out_illegal  out  1      encoding unsupported; out_imm is 0
//  out_tag      out  TAG_W  sideband tag
// BEHAVIOUR
//  Clock, reset and transfer rules
//  - Single clock clk. rst is synchronous and active-high.
//  - Reset: out_valid=0, in_ready=1, out_imm=0, out_fmt=0, out_illegal=0, out_instr=0, out_tag=0; both skid entries empty.
//  - A transfer occurs on a clk edge with valid&ready. Latency is 1 cycle from input transfer to out_valid.
//  - Throughput: 1 instruction per cycle while out_ready=1.
//  Skid buffer
//  - Main entry plus skid entry.
//  - in_ready is a register: it is 0 only when the skid entry is occupied.
//  - An input accepted while the main entry is held (out_valid & !out_ready) goes to the skid entry.
//  - The skid entry drains into the main entry on the next output transfer.
//  - Ordering is strictly FIFO. No entry is duplicated or lost.
//  - Simultaneous input and output transfer with the skid empty: the main entry is overwritten and out_valid stays 1.
//  - Outputs are stable while out_valid & !out_ready.
//  Flush and reset priority
//  - flush (priority below rst, above everything else): next cycle out_valid=0, in_ready=1, skid empty.
//  - An input presented in the flush cycle is dropped.
//  - rst mid-operation behaves identically to flush and also clears the data registers.
//  Decode (opcode = instr[6:0], f3 = instr[14:12]); all sign extension is from instr[31] to XLEN
//  - 0000011 load, 1100111 JALR, 0010011 OP-IMM (non-shift) -> I: sext(instr[31:20]).
//  - 0100011 -> S: sext({instr[31:25], instr[11:7]}).
//  - 1100011 -> B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
//  - 1101111 -> J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
//  - 0110111 / 0010111 -> U: sext({instr[31:12], 12'b0}); bit 31 sign-extends when XLEN=64.
//  - OP-IMM with f3=001/101 -> SH:
//    - XLEN=64: zext(instr[25:20]).
//    - XLEN=32: zext(instr[24:20]); instr[25]=1 -> illegal.
//  - 0011011 OP-IMM-32:
//    - XLEN=64: shifts give zext(instr[24:20]); others decode as I.
//    - XLEN=32: illegal.
//  - 1110011 with EN_CSR=1 -> Z when f3[2]=1: zext(instr[19:15]). f3[2]=0 -> NONE, imm 0.
//  - 0110011, 0001111 -> NONE, imm 0, legal.
//  - Any other opcode, or instr[1:0] != 2'b11 -> illegal=1, fmt=NONE, imm=0. The X value is never produced.
// STRUCTURE
//  - Package imm_pkg: opcode localparams, fmt codes FMT_NONE..FMT_Z, XLEN legality check.
//  - Sub-module imm_gen_comb:
//    - Purely combinational instr -> {imm, fmt, illegal}, parametrised by XLEN and EN_CSR.
//    - The top holds the skid/handshake logic only.
//  - Elaboration error if XLEN is not 32 or 64.
// TESTING
//  1. XLEN=32: instr 0xFFF00093 (addi x1,x0,-1) -> next cycle out_valid=1, imm=0xFFFFFFFF, fmt=I, illegal=0.
//  2. instr 0xFE000EE3 (beq -4) -> imm=0xFFFFFFFC, fmt=B.
//     XLEN=64: 0x800000B7 (lui 0x80000) -> imm=0xFFFFFFFF80000000, fmt=U.
//  3. XLEN=32: 0x02009093 (slli shamt 32) -> illegal=1, imm=0.
//     XLEN=64: same word -> fmt=SH, imm=32.
//     Opcode 0x7F -> illegal=1.
//  4. Stream 4 instructions with tags 1..4; hold out_ready=0 for 3 cycles ->
//     in_ready falls after the 2nd is held; tags emerge as 1,2,3,4 with none lost or duplicated.
//  5. flush asserted during a stall with both entries full -> next cycle out_valid=0, in_ready=1.
//     Later input tag 9 emerges alone.
//  6. rst pulsed mid-stream -> all outputs at reset values next cycle.
//     Random valid/ready stress checked against a reference queue model.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared opcode encodings, immediate format codes and XLEN legality helper
// for the immediate-decode stage.
package imm_pkg;

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_IMM_32   = 7'b0011011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_SH   = 3'd6,
        FMT_Z    = 3'd7
    } fmt_e;

    function automatic bit xlen_ok(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_gen_comb.sv
// Purpose: combinational RISC-V immediate extractor and extender, instr -> {imm, fmt, illegal}.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing stage owns all flow control.
module imm_gen_comb
    import imm_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit EN_CSR = 1'b1
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt,
    output logic            illegal
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic        is_shift;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    logic [31:0] raw;
    logic        sx;

    assign opcode   = instr[6:0];
    assign f3       = instr[14:12];
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};

    // raw holds the low 32 bits; sx says whether bits above 31 replicate raw[31]
    always_comb begin
        raw     = '0;
        sx      = 1'b0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        case (opcode)
            OP_LOAD, OP_JALR: begin
                fmt = FMT_I; raw = imm_i; sx = 1'b1;
            end
            OP_IMM: begin
                if (!is_shift) begin
                    fmt = FMT_I; raw = imm_i; sx = 1'b1;
                end else if (XLEN == 64) begin
                    fmt = FMT_SH; raw = {26'b0, instr[25:20]};
                end else if (instr[25]) begin
                    illegal = 1'b1;
                end else begin
                    fmt = FMT_SH; raw = {27'b0, instr[24:20]};
                end
            end
            OP_IMM_32: begin
                if (XLEN == 32) begin
                    illegal = 1'b1;
                end else if (is_shift) begin
                    fmt = FMT_SH; raw = {27'b0, instr[24:20]};
                end else begin
                    fmt = FMT_I; raw = imm_i; sx = 1'b1;
                end
            end
            OP_STORE:  begin fmt = FMT_S; raw = imm_s; sx = 1'b1; end
            OP_BRANCH: begin fmt = FMT_B; raw = imm_b; sx = 1'b1; end
            OP_JAL:    begin fmt = FMT_J; raw = imm_j; sx = 1'b1; end
            OP_LUI, OP_AUIPC: begin
                fmt = FMT_U; raw = imm_u; sx = 1'b1;
            end
            OP_SYSTEM: begin
                if (!EN_CSR) begin
                    illegal = 1'b1;
                end else if (f3[2]) begin
                    fmt = FMT_Z; raw = {27'b0, instr[19:15]};
                end
            end
            OP_OP, OP_MISC_MEM: ;
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            raw = '0;
            sx  = 1'b0;
            fmt = FMT_NONE;
        end
    end

    always_comb begin
        imm       = {XLEN{sx & raw[31]}};
        imm[31:0] = raw;
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Purpose: registered immediate-decode stage between fetch and issue, with a 2-entry skid buffer.
// Latency: 1 cycle from input transfer to out_valid; 1 instruction/cycle while out_ready=1.
// Backpressure: in_ready is registered and drops only while the skid entry is occupied.
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int TAG_W  = 5,
    parameter bit EN_CSR = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    if (!xlen_ok(XLEN)) begin : g_bad_xlen
        $error("imm_decode_stage: XLEN must be 32 or 64");
    end

    typedef struct packed {
        logic [31:0]      instr;
        logic [XLEN-1:0]  imm;
        fmt_e             fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } ent_t;

    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;
    logic            dec_illegal;
    ent_t            dec_ent, main_q, skid_q;
    logic            skid_vld;
    logic            in_xfer, out_xfer;

    imm_gen_comb #(.XLEN(XLEN), .EN_CSR(EN_CSR)) u_gen (
        .instr   (in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    assign dec_ent  = '{instr: in_instr, imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal, tag: in_tag};
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // in_ready is low whenever skid is full, so in_xfer never coincides with a skid drain
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            skid_vld  <= 1'b0;
            in_ready  <= 1'b1;
            main_q    <= '0;
            skid_q    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            skid_vld  <= 1'b0;
            in_ready  <= 1'b1;
        end else if (out_xfer) begin
            if (skid_vld) begin
                main_q   <= skid_q;
                skid_vld <= 1'b0;
                in_ready <= 1'b1;
            end else if (in_xfer) begin
                main_q <= dec_ent;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_xfer) begin
            if (out_valid) begin
                skid_q   <= dec_ent;
                skid_vld <= 1'b1;
                in_ready <= 1'b0;
            end else begin
                main_q    <= dec_ent;
                out_valid <= 1'b1;
            end
        end
    end

    assign out_instr   = main_q.instr;
    assign out_imm     = main_q.imm;
    assign out_fmt     = main_q.fmt;
    assign out_illegal = main_q.illegal;
    assign out_tag     = main_q.tag;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: XLEN=32 and XLEN=64 instances driven in lockstep,
// directed vectors plus a queue-based scoreboard under random valid/ready/flush.
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [4:0]  in_tag;

    logic        in_ready32, out_valid32, ill32;
    logic [31:0] out_instr32, out_imm32;
    logic [2:0]  fmt32;
    logic [4:0]  tag32;
    logic        in_ready64, out_valid64, ill64;
    logic [31:0] out_instr64;
    logic [63:0] out_imm64;
    logic [2:0]  fmt64;
    logic [4:0]  tag64;

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32), .TAG_W(5), .EN_CSR(1'b1)) u_dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready), .out_instr(out_instr32),
        .out_imm(out_imm32), .out_fmt(fmt32), .out_illegal(ill32), .out_tag(tag32)
    );

    imm_decode_stage #(.XLEN(64), .TAG_W(5), .EN_CSR(1'b1)) u_dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready), .out_instr(out_instr64),
        .out_imm(out_imm64), .out_fmt(fmt64), .out_illegal(ill64), .out_tag(tag64)
    );

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  tag;
        logic [63:0] imm32, imm64;
        logic [2:0]  fmt32, fmt64;
        logic        ill32, ill64;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference decoder written from the ISA field layout, working in 64 bits
    function automatic void ref_dec(input logic [31:0] w, input int xl,
                                    output logic [63:0] imm, output logic [2:0] fmt,
                                    output logic ill);
        logic [63:0] v;
        logic        shf;
        v   = '0;
        fmt = 3'd0;
        ill = 1'b0;
        shf = (w[14:12] == 3'b001) || (w[14:12] == 3'b101);
        case (w[6:0])
            7'h03, 7'h67: begin fmt = 3'd1; v = 64'($signed(w[31:20])); end
            7'h13: begin
                if (!shf) begin fmt = 3'd1; v = 64'($signed(w[31:20])); end
                else if (xl == 64) begin fmt = 3'd6; v = {58'd0, w[25:20]}; end
                else if (w[25]) ill = 1'b1;
                else begin fmt = 3'd6; v = {59'd0, w[24:20]}; end
            end
            7'h1B: begin
                if (xl == 32) ill = 1'b1;
                else if (shf) begin fmt = 3'd6; v = {59'd0, w[24:20]}; end
                else begin fmt = 3'd1; v = 64'($signed(w[31:20])); end
            end
            7'h23: begin fmt = 3'd2; v = 64'($signed({w[31:25], w[11:7]})); end
            7'h63: begin fmt = 3'd3; v = 64'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0})); end
            7'h6F: begin fmt = 3'd5; v = 64'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0})); end
            7'h37, 7'h17: begin fmt = 3'd4; v = 64'($signed({w[31:12], 12'h000})); end
            7'h73: if (w[14]) begin fmt = 3'd7; v = {59'd0, w[19:15]}; end
            7'h33, 7'h0F: ;
            default: ill = 1'b1;
        endcase
        if (ill) begin v = '0; fmt = 3'd0; end
        imm = (xl == 32) ? {32'd0, v[31:0]} : v;
    endfunction

    logic        held = 1'b0;
    logic [31:0] h_instr;
    logic [4:0]  h_tag;
    logic [31:0] h_imm;

    always @(negedge clk) begin
        exp_t e;
        if (held) begin
            chk("hold_instr", 64'(out_instr32), 64'(h_instr));
            chk("hold_tag",   64'(tag32),       64'(h_tag));
            chk("hold_imm",   64'(out_imm32),   64'(h_imm));
        end
        held    = out_valid32 && !out_ready && !rst && !flush;
        h_instr = out_instr32;
        h_tag   = tag32;
        h_imm   = out_imm32;

        if (out_valid32 && out_ready && !rst) begin
            if (q.size() == 0) begin
                chk("spurious_out", 64'(out_valid32), 64'd0);
            end else begin
                e = q.pop_front();
                chk("sb_tag",    64'(tag32),       64'(e.tag));
                chk("sb_instr",  64'(out_instr32), 64'(e.instr));
                chk("sb_imm32",  64'(out_imm32),   e.imm32);
                chk("sb_fmt32",  64'(fmt32),       64'(e.fmt32));
                chk("sb_ill32",  64'(ill32),       64'(e.ill32));
                chk("sb_vld64",  64'(out_valid64), 64'd1);
                chk("sb_tag64",  64'(tag64),       64'(e.tag));
                chk("sb_imm64",  out_imm64,        e.imm64);
                chk("sb_fmt64",  64'(fmt64),       64'(e.fmt64));
                chk("sb_ill64",  64'(ill64),       64'(e.ill64));
            end
        end
        if (rst || flush) begin
            q.delete();
        end else if (in_valid && in_ready32) begin
            e.instr = in_instr;
            e.tag   = in_tag;
            ref_dec(in_instr, 32, e.imm32, e.fmt32, e.ill32);
            ref_dec(in_instr, 64, e.imm64, e.fmt64, e.ill64);
            q.push_back(e);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w, input logic [4:0] t);
        in_valid = 1'b1;
        in_instr = w;
        in_tag   = t;
        for (int n = 0; n < 40; n++) begin
            if (in_ready32) begin
                step();
                in_valid = 1'b0;
                return;
            end
            step();
        end
        chk("send_accept", 64'(in_ready32), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_vld"},   64'(out_valid32), 64'd0);
        chk({name, "_rdy"},   64'(in_ready32),  64'd1);
        chk({name, "_imm"},   64'(out_imm32),   64'd0);
        chk({name, "_fmt"},   64'(fmt32),       64'd0);
        chk({name, "_ill"},   64'(ill32),       64'd0);
        chk({name, "_instr"}, 64'(out_instr32), 64'd0);
        chk({name, "_tag"},   64'(tag32),       64'd0);
        chk({name, "_imm64"}, out_imm64,        64'd0);
    endtask

    logic [6:0] ops [14] = '{7'h03, 7'h67, 7'h13, 7'h13, 7'h1B, 7'h23, 7'h63,
                             7'h6F, 7'h37, 7'h17, 7'h73, 7'h33, 7'h0F, 7'h7F};

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_tag = '0;
        repeat (3) step();
        chk_reset_vals("reset");
        rst = 1'b0;
        step();

        // Directed decode vectors
        send(32'hFFF00093, 5'd1);
        chk("addi_vld",  64'(out_valid32), 64'd1);
        chk("addi_imm",  64'(out_imm32),   64'hFFFF_FFFF);
        chk("addi_fmt",  64'(fmt32),       64'd1);
        chk("addi_ill",  64'(ill32),       64'd0);
        send(32'hFE000EE3, 5'd2);
        chk("beq_imm",   64'(out_imm32),   64'hFFFF_FFFC);
        chk("beq_fmt",   64'(fmt32),       64'd3);
        send(32'h800000B7, 5'd3);
        chk("lui_imm64", out_imm64,        64'hFFFF_FFFF_8000_0000);
        chk("lui_fmt64", 64'(fmt64),       64'd4);
        send(32'h02009093, 5'd4);
        chk("slli32_ill", 64'(ill32),      64'd1);
        chk("slli32_imm", 64'(out_imm32),  64'd0);
        chk("slli64_fmt", 64'(fmt64),      64'd6);
        chk("slli64_imm", out_imm64,       64'd32);
        send(32'h0000007F, 5'd5);
        chk("op7f_ill",  64'(ill32),       64'd1);
        chk("op7f_ill64", 64'(ill64),      64'd1);
        step();
        chk("idle_vld",  64'(out_valid32), 64'd0);

        // Stall with four in flight; order checked by the scoreboard
        out_ready = 1'b0;
        fork
            begin
                send(32'h00100093, 5'd1);
                send(32'h00200113, 5'd2);
                chk("stall_rdy_low", 64'(in_ready32), 64'd0);
                send(32'h00300193, 5'd3);
                send(32'h00400213, 5'd4);
            end
            begin
                repeat (5) step();
                out_ready = 1'b1;
            end
        join
        repeat (3) step();
        chk("stream_drain", 64'(q.size()), 64'd0);

        // Flush with both entries full
        out_ready = 1'b0;
        send(32'h00500293, 5'd6);
        send(32'h00600313, 5'd7);
        chk("flush_pre_rdy", 64'(in_ready32), 64'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_vld", 64'(out_valid32), 64'd0);
        chk("flush_rdy", 64'(in_ready32),  64'd1);
        in_valid = 1'b1; in_instr = 32'h00A00513; in_tag = 5'd10; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_drop_vld", 64'(out_valid32), 64'd0);
        out_ready = 1'b1;
        send(32'h00900493, 5'd9);
        chk("post_flush_vld", 64'(out_valid32), 64'd1);
        chk("post_flush_tag", 64'(tag32),       64'd9);
        step();
        chk("post_flush_alone", 64'(out_valid32), 64'd0);

        // Reset mid-stream
        out_ready = 1'b0;
        send(32'hFFF00093, 5'd11);
        send(32'h800000B7, 5'd12);
        rst = 1'b1;
        step();
        chk_reset_vals("midrst");
        rst = 1'b0;
        out_ready = 1'b1;
        step();

        // Random stress against the scoreboard
        for (int i = 0; i < 800; i++) begin
            logic [31:0] w;
            w = $urandom;
            if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 13)];
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = w;
            in_tag    = 5'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) step();
        chk("stress_drain", 64'(q.size()), 64'd0);
        chk("stress_idle",  64'(out_valid32), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
